// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared datapath widths and the extender mode encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int IMM_W  = 16;
  localparam int WORD_W = 32;

  // Extension modes, one per distinct result shape.
  typedef enum logic [2:0] {
    EXT_SH = 3'd0,  // sign-extend halfword
    EXT_ZH = 3'd1,  // zero-extend halfword
    EXT_SB = 3'd2,  // sign-extend byte
    EXT_ZB = 3'd3,  // zero-extend byte
    EXT_UP = 3'd4   // upper placement (LUI)
  } ext_mode_e;

  // Collapse the three mode bits into one mode. Upper wins over byte,
  // byte wins over halfword.
  function automatic ext_mode_e encode_mode(input logic upper,
                                            input logic byte_mode,
                                            input logic sign_ext);
    ext_mode_e m;
    if (upper)          m = EXT_UP;
    else if (byte_mode) m = sign_ext ? EXT_SB : EXT_ZB;
    else                m = sign_ext ? EXT_SH : EXT_ZH;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sign_extender_if.sv
`default_nettype none
// ============================================================================
// Module      : sign_extender_if
// Description : Request/result bundle for the immediate/data extender.
// Revision    : 1.0 - initial release
// ============================================================================
interface sign_extender_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic [IN_W-1:0]  in;
  logic             sign_extend;
  logic             byte_mode;
  logic             upper;
  logic [OUT_W-1:0] out;
  logic             out_valid;

  // Requester side: drives the field and mode bits, observes the result.
  modport master (
    output in_valid, in, sign_extend, byte_mode, upper,
    input  out, out_valid
  );

  // Extender side.
  modport slave (
    input  in_valid, in, sign_extend, byte_mode, upper,
    output out, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/sign_extend_comb.sv
`default_nettype none
// ============================================================================
// Module      : sign_extend_comb
// Description : Pure combinational field extender (halfword/byte/upper).
// Revision    : 1.0 - initial release
// ============================================================================
module sign_extend_comb
  import mips_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  wire ext_mode_e        i_mode,
  input  wire logic [IN_W-1:0]  i_in,
  output logic      [OUT_W-1:0] o_out
);

  localparam int c_PAD_H = OUT_W - IN_W;
  localparam int c_PAD_B = OUT_W - 8;

  // Select the extended shape for the decoded mode.
  always_comb begin
    o_out = '0;
    case (i_mode)
      EXT_UP:  o_out = {i_in, {c_PAD_H{1'b0}}};
      EXT_SB:  o_out = {{c_PAD_B{i_in[7]}}, i_in[7:0]};
      EXT_ZB:  o_out = {{c_PAD_B{1'b0}}, i_in[7:0]};
      EXT_SH:  o_out = {{c_PAD_H{i_in[IN_W-1]}}, i_in};
      EXT_ZH:  o_out = {{c_PAD_H{1'b0}}, i_in};
      default: o_out = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sign_extender.sv
`default_nettype none
// ============================================================================
// Module      : sign_extender
// Description : Registered immediate/data extender with a valid flag,
//               one-cycle latency, no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_extender
  import mips_pkg::*;
#(
  parameter int IN_W  = IMM_W,
  parameter int OUT_W = WORD_W
) (
  input  wire logic clk,
  input  wire logic reset,
  sign_extender_if.slave bus
);

  ext_mode_e        w_mode;
  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;

  assign w_mode = encode_mode(bus.upper, bus.byte_mode, bus.sign_extend);

  sign_extend_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .i_mode (w_mode),
    .i_in   (bus.in),
    .o_out  (w_ext)
  );

  // Capture the result only for valid inputs; out holds across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out <= w_ext;
      end
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_sign_extender.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sign_extender
// Description : Directed table-driven bench for sign_extender.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_extender;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sign_extender_if #(.IN_W(16), .OUT_W(32)) bus ();

  sign_extender #(.IN_W(16), .OUT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] din;
    logic        se;
    logic        bm;
    logic        up;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic se,
                       input logic bm, input logic up);
    bus.in_valid    = v;
    bus.in          = d;
    bus.sign_extend = se;
    bus.byte_mode   = bm;
    bus.upper       = up;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{"sh_15",      16'h000F, 1'b1, 1'b0, 1'b0, 32'h0000000F};
    vecs[1]  = '{"sh_m12",     16'hFFF4, 1'b1, 1'b0, 1'b0, 32'hFFFFFFF4};
    vecs[2]  = '{"sh_32",      16'h0020, 1'b1, 1'b0, 1'b0, 32'h00000020};
    vecs[3]  = '{"sh_m512",    16'hFE00, 1'b1, 1'b0, 1'b0, 32'hFFFFFE00};
    vecs[4]  = '{"zh_m5",      16'hFFFB, 1'b0, 1'b0, 1'b0, 32'h0000FFFB};
    vecs[5]  = '{"zh_8000",    16'h8000, 1'b0, 1'b0, 1'b0, 32'h00008000};
    vecs[6]  = '{"sh_8000",    16'h8000, 1'b1, 1'b0, 1'b0, 32'hFFFF8000};
    vecs[7]  = '{"sh_7fff",    16'h7FFF, 1'b1, 1'b0, 1'b0, 32'h00007FFF};
    vecs[8]  = '{"zh_ffff",    16'hFFFF, 1'b0, 1'b0, 1'b0, 32'h0000FFFF};
    vecs[9]  = '{"sb_12f0",    16'h12F0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFF0};
    vecs[10] = '{"zb_12f0",    16'h12F0, 1'b0, 1'b1, 1'b0, 32'h000000F0};
    vecs[11] = '{"sb_ab7f",    16'hAB7F, 1'b1, 1'b1, 1'b0, 32'h0000007F};

    reset = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", bus.out, 32'h0);
    check("reset_valid", {31'b0, bus.out_valid}, 32'h0);

    // Release reset with no valid input: out_valid must stay low.
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle_valid", {31'b0, bus.out_valid}, 32'h0);

    // Table vectors, one per cycle, checked one cycle later.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) drive(1'b1, vecs[i].din, vecs[i].se, vecs[i].bm, vecs[i].up);
      @(posedge clk); #1;
      check(vecs[i].name, bus.out, vecs[i].exp);
      check({vecs[i].name, "_valid"}, {31'b0, bus.out_valid}, 32'h1);
    end

    // Upper overrides both other mode bits.
    @(negedge clk) drive(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("upper_abcd", bus.out, 32'hABCD0000);

    // Back-to-back then a bubble with unknown mode bits.
    @(negedge clk) drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_first", bus.out, 32'h00000001);
    check("b2b_first_valid", {31'b0, bus.out_valid}, 32'h1);
    @(negedge clk) drive(1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("b2b_second", bus.out, 32'hFFFFFFFF);
    check("b2b_second_valid", {31'b0, bus.out_valid}, 32'h1);
    @(negedge clk) drive(1'b0, 16'hxxxx, 1'bx, 1'bx, 1'bx);
    @(posedge clk); #1;
    check("bubble_valid", {31'b0, bus.out_valid}, 32'h0);
    check("bubble_hold", bus.out, 32'hFFFFFFFF);

    // Asynchronous reset between edges with a valid input in flight.
    @(negedge clk) drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", bus.out, 32'h0);
    check("async_reset_valid", {31'b0, bus.out_valid}, 32'h0);
    @(posedge clk); #1;
    check("reset_held_out", bus.out, 32'h0);
    @(negedge clk) begin
      reset = 1'b0;
      drive(1'b0, 16'h1234, 1'b0, 1'b0, 1'b0);
    end
    @(posedge clk); #1;
    check("after_release_valid", {31'b0, bus.out_valid}, 32'h0);
    check("after_release_out", bus.out, 32'h0);
    @(negedge clk) drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("first_after_reset", bus.out, 32'h00001234);
    check("first_after_reset_valid", {31'b0, bus.out_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
